store_buffer: RTL and testbench

//   Posted-write FIFO directly downstream of store_memory_encoder. It accepts encoded stores
//   (word address, lane-shifted data, 32-bit bit mask, misalignment flag) from the MEM stage.
//   It drains them in order to the data-memory bus over a valid/ready handshake, so that

---
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store encoder and the data-memory bus.
// Stores retire into the buffer and drain in order over a valid/ready handshake.
// Misaligned stores (in_exception) are dropped and reported with a one-cycle store_fault.
// Optional feature macro: STORE_BUFFER_HAZARD_EN adds a load/store address hazard check
// (ld_check_addr / ld_hazard ports).
//
// Handshake semantics (both sides): a transfer happens at a rising edge where valid and
// ready are both high. A producer holds valid and payload stable until that edge. in_ready
// depends only on the registered occupancy, never on mem_ready, so a full buffer refuses
// input even in a cycle where the head drains.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_addr,
    input  logic [31:0]             in_data,
    input  logic [31:0]             in_mask,
    input  logic                    in_exception,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [31:0]             mem_wmask,
    output logic                    store_fault,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef STORE_BUFFER_HAZARD_EN
    ,
    input  logic [31:0]             ld_check_addr,
    output logic                    ld_hazard
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage array; deliberately not reset, only pointers and occupancy are.
    logic [29:0] r_addr_mem [DEPTH];
    logic [31:0] r_data_mem [DEPTH];
    logic [31:0] r_mask_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_fault;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Byte offset of the store address is meaningless for a word-wide bus.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^in_addr[1:0];

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = in_valid && !w_full;
    assign w_push   = w_accept && !in_exception;
    assign w_pop    = !w_empty && mem_ready;

    assign in_ready    = !w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign store_fault = r_fault;
    assign mem_valid   = !w_empty;
    assign mem_addr    = {r_addr_mem[r_rd_ptr], 2'b00};
    assign mem_wdata   = r_data_mem[r_rd_ptr];
    assign mem_wmask   = w_empty ? 32'h0 : r_mask_mem[r_rd_ptr];

    // Write accepted, non-faulting stores into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= in_addr[31:2];
            r_data_mem[r_wr_ptr] <= in_data;
            r_mask_mem[r_wr_ptr] <= in_mask;
        end
    end

    // Pointers, occupancy and the fault pulse; reset abandons any pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_fault <= w_accept && in_exception;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_BUFFER_HAZARD_EN
    // An entry is live when its distance from the head is below the occupancy; the head
    // being drained this cycle is still live, so a load never overtakes it.
    logic [DEPTH-1:0] w_ent_valid;
    logic [DEPTH-1:0] w_ent_match;
    logic             w_unused_ld_lsb;

    assign w_unused_ld_lsb = ^ld_check_addr[1:0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_hazard
        logic [PW-1:0] w_offs;
        assign w_offs         = PW'(g) - r_rd_ptr;
        assign w_ent_valid[g] = ({1'b0, w_offs} < r_count);
        assign w_ent_match[g] = (r_addr_mem[g] == ld_check_addr[31:2]);
    end

    assign ld_hazard = |(w_ent_valid & w_ent_match);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4).
// A negedge bus monitor pops expected stores from exp_q and checks payload stability
// across stalls. With STORE_BUFFER_HAZARD_EN defined the load-hazard ports are exercised.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 96;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [31:0] in_mask;
  logic        in_exception;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic        store_fault;
  logic        empty;
  logic [$clog2(DEPTH):0] count;
`ifdef STORE_BUFFER_HAZARD_EN
  logic [31:0] ld_check_addr;
  logic        ld_hazard;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_mask      (in_mask),
    .in_exception (in_exception),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .store_fault  (store_fault),
    .empty        (empty),
    .count        (count)
`ifdef STORE_BUFFER_HAZARD_EN
    ,
    .ld_check_addr(ld_check_addr),
    .ld_hazard    (ld_hazard)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] held;
  logic [W-1:0] e;
  logic         tog_run;
  logic [31:0]  s_a, s_d, s_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus monitor: sampled at negedge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(mem_valid), 32'd1);
        check("stall_addr",  mem_addr,  held[95:64]);
        check("stall_wdata", mem_wdata, held[63:32]);
        check("stall_wmask", mem_wmask, held[31:0]);
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("bus_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr",  mem_addr,  e[95:64]);
          check("bus_wdata", mem_wdata, e[63:32]);
          check("bus_wmask", mem_wmask, e[31:0]);
        end
      end
      prev_stall = mem_valid && !mem_ready;
      held = {mem_addr, mem_wdata, mem_wmask};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m,
                      input logic exc);
    int   waited;
    logic hs;
    waited       = 0;
    hs           = 1'b0;
    in_valid     = 1'b1;
    in_addr      = a;
    in_data      = d;
    in_mask      = m;
    in_exception = exc;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!hs && waited < 300);
    if (!hs) check("send_timeout", 32'(hs), 32'd1);
    in_valid     = 1'b0;
    in_exception = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!empty && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(empty), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_addr      = '0;
    in_data      = '0;
    in_mask      = '0;
    in_exception = 1'b0;
    mem_ready    = 1'b0;
    tog_run      = 1'b0;
`ifdef STORE_BUFFER_HAZARD_EN
    ld_check_addr = '0;
`endif
    cycle();
    cycle();
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_empty",     32'(empty), 32'd1);
    check("rst_count",     32'(count), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_fault",     32'(store_fault), 32'd0);
    check("rst_wmask",     mem_wmask, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cycle();

    // Single store, memory ready: visible one cycle after enqueue, gone after handshake.
    mem_ready = 1'b1;
    exp_q.push_back({32'h104, 32'h0000ff00, 32'h0000ff00});
    send(32'h104, 32'h0000ff00, 32'h0000ff00, 1'b0);
    check("t2_mem_valid", 32'(mem_valid), 32'd1);
    check("t2_mem_addr",  mem_addr, 32'h104);
    check("t2_wdata",     mem_wdata, 32'h0000ff00);
    check("t2_wmask",     mem_wmask, 32'h0000ff00);
    cycle();
    check("t2_empty",     32'(empty), 32'd1);
    check("t2_wmask0",    mem_wmask, 32'h0);

    // Misaligned store is dropped with a one-cycle fault pulse.
    send(32'h3, 32'h12345678, 32'hffffffff, 1'b1);
    check("t4_fault",     32'(store_fault), 32'd1);
    check("t4_count",     32'(count), 32'd0);
    check("t4_mem_valid", 32'(mem_valid), 32'd0);
    cycle();
    check("t4_fault_off", 32'(store_fault), 32'd0);
    check("t4_mem_valid2", 32'(mem_valid), 32'd0);

    // Fill with memory stalled, hold a 5th request, then drain in order.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_a = 32'(i * 4);
      s_d = 32'hC0DE0000 | 32'(i);
      s_m = 32'h000000ff << (8 * i);
      exp_q.push_back({s_a, s_d, s_m});
      send(s_a, s_d, s_m, 1'b0);
    end
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_in_ready0",  32'(in_ready), 32'd0);
    exp_q.push_back({32'h10, 32'hC0DE0004, 32'hffffffff});
    in_valid = 1'b1;
    in_addr  = 32'h10;
    in_data  = 32'hC0DE0004;
    in_mask  = 32'hffffffff;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("t3_held_count", 32'(count), 32'd4);
      check("t3_held_ready", 32'(in_ready), 32'd0);
      check("t3_head_addr",  mem_addr, 32'h0);
    end
    mem_ready = 1'b1;
    cycle();
    check("t3_after_pop_count", 32'(count), 32'd3);
    check("t3_after_pop_ready", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    check("t3_push_pop_count", 32'(count), 32'd3);
    wait_empty("t3_drained");
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Stream of 16 stores with mem_ready toggling, one misaligned store mid-stream.
    tog_run   = 1'b1;
    mem_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          s_a = 32'h1000 + 32'(i * 4);
          s_d = 32'hA5000000 | 32'(i);
          s_m = (i % 2 == 1) ? 32'hffff0000 : 32'h0000ffff;
          if (i == 7) begin
            send(s_a | 32'h1, s_d, s_m, 1'b1);
          end else begin
            exp_q.push_back({s_a, s_d, s_m});
            send(s_a, s_d, s_m, 1'b0);
          end
        end
        wait_empty("t5_drained");
        tog_run = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (tog_run && n < 2000) begin
          @(posedge clk);
          #1;
          mem_ready = !mem_ready;
          n++;
        end
      end
    join
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with entries pending.
    mon_en    = 1'b0;
    mem_ready = 1'b0;
    send(32'h200, 32'h11111111, 32'hffffffff, 1'b0);
    send(32'h204, 32'h22222222, 32'hffffffff, 1'b0);
    check("t1_pre_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_mem_valid", 32'(mem_valid), 32'd0);
    check("t1_empty",     32'(empty), 32'd1);
    check("t1_count",     32'(count), 32'd0);
    check("t1_in_ready",  32'(in_ready), 32'd1);
    check("t1_wmask",     mem_wmask, 32'h0);
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    cycle();
    mon_en = 1'b1;

`ifdef STORE_BUFFER_HAZARD_EN
    // Load hazard against a pending store.
    mem_ready = 1'b0;
    exp_q.push_back({32'h20, 32'h55aa55aa, 32'hffffffff});
    send(32'h20, 32'h55aa55aa, 32'hffffffff, 1'b0);
    ld_check_addr = 32'h22;
    #1;
    check("t6_hit", 32'(ld_hazard), 32'd1);
    ld_check_addr = 32'h24;
    #1;
    check("t6_miss", 32'(ld_hazard), 32'd0);
    mem_ready = 1'b1;
    wait_empty("t6_drained");
    ld_check_addr = 32'h22;
    #1;
    check("t6_after_drain", 32'(ld_hazard), 32'd0);
`endif

    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
